uart_rx_top: RTL and testbench

- 8N1 UART receiver: the far-end counterpart of the UART transmitter. It consumes the serial Tx line, either from another board or looped back in test.
- Synchronises the line, finds the start bit, samples each bit at mid-period, and places the received byte in a receive buffer register (RBR).
- The RBR holds the byte with a valid flag until the consumer (core I/O port) acknowledges it.
- Reports framing and overrun errors.

---
 rtl/uart_rx_top.sv | 167 ++++++++++++++++
 tb/tb_uart_rx_top.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_top.sv
// 8N1 UART receiver.
// Double-flop synchronises the serial line, then finds the start bit and
// samples each bit at mid-period. The byte is placed in a receive buffer
// register (RBR) that holds it until the consumer acknowledges. The receiver
// also reports sticky framing and overrun errors.
module uart_rx_top #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Rx,
    input  logic       RBR_rd,
    output logic [7:0] Data_out,
    output logic       RBR_Valid,
    output logic       Framing_Err,
    output logic       Overrun
);

    localparam int unsigned HALF_BIT  = CLKS_PER_BIT / 2;
    localparam logic [15:0] HALF_LOAD = 16'(HALF_BIT - 1);
    localparam logic [15:0] BIT_LOAD  = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_e;

    logic       rx_meta_q;
    logic       rx_s_q;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;
    logic        ovr_q, ovr_d;

    logic        expire;

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= Rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    assign expire = (cnt_q == 16'd0);

    // Next-state logic: frame FSM, bit counter, shift register and RBR flags.
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = valid_q;
        ferr_d    = ferr_q;
        ovr_d     = ovr_q;

        // Consumer acknowledge clears the buffer flags; a load below overrides.
        if (RBR_rd) begin
            valid_d = 1'b0;
            ferr_d  = 1'b0;
            ovr_d   = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    cnt_d   = HALF_LOAD;
                end
            end
            START: begin
                if (expire) begin
                    if (!rx_s_q) begin
                        state_d   = DATA;
                        cnt_d     = BIT_LOAD;
                        bit_idx_d = 3'd0;
                    end else begin
                        // Line went back high before mid-start: glitch.
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            DATA: begin
                if (expire) begin
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    cnt_d     = BIT_LOAD;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            STOP: begin
                if (expire) begin
                    if (rx_s_q) begin
                        // Good stop: load wins over a same-cycle acknowledge.
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        ovr_d   = ovr_d | (valid_q & ~RBR_rd);
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            WAIT_HIGH: begin
                // Hold off until the line recovers so a break is not re-read as starts.
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Receiver and RBR state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= 16'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign Data_out    = data_q;
    assign RBR_Valid   = valid_q;
    assign Framing_Err = ferr_q;
    assign Overrun     = ovr_q;

endmodule

// File: tb/tb_uart_rx_top.sv
// Scoreboard bench for uart_rx_top with CLKS_PER_BIT=16.
// Stimulus pushes the expected RBR contents for each frame; a negedge monitor
// pops and compares whenever the receiver loads a byte or raises Framing_Err.
module tb_uart_rx_top;

    localparam int C = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rbr_rd = 1'b0;
    logic [7:0] data_out;
    logic       rbr_valid;
    logic       framing_err;
    logic       overrun;

    typedef struct packed {
        logic [7:0] data;
        logic       valid;
        logic       ferr;
        logic       ovr;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    uart_rx_top #(.CLKS_PER_BIT(C)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .Rx         (rx),
        .RBR_rd     (rbr_rd),
        .Data_out   (data_out),
        .RBR_Valid  (rbr_valid),
        .Framing_Err(framing_err),
        .Overrun    (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    function automatic exp_t mk(input logic [7:0] d, input logic v, input logic f, input logic o);
        exp_t e;
        e.data  = d;
        e.valid = v;
        e.ferr  = f;
        e.ovr   = o;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Bench-side transmitter: called at a negedge, returns at a negedge with the line high.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int stop_len);
        rx = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (C) @(negedge clk);
        end
        rx = stop_bit;
        repeat (stop_len) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic ack;
        rbr_rd = 1'b1;
        @(negedge clk);
        rbr_rd = 1'b0;
    endtask

    // Sends a good frame and checks RBR_Valid rises exactly 3+8+144=155 edges after the fall.
    task automatic send_timed(input logic [7:0] b, input string tag);
        fork
            send_frame(b, 1'b1, C);
            begin
                repeat (154) @(posedge clk);
                @(negedge clk);
                check({tag, " valid after edge 154"}, 32'(rbr_valid), 32'd0);
                @(posedge clk);
                @(negedge clk);
                check({tag, " valid after edge 155"}, 32'(rbr_valid), 32'd1);
                check({tag, " data after edge 155"}, 32'(data_out), 32'(b));
            end
        join
    endtask

    // Monitor: any load or framing event pops one expected RBR snapshot.
    logic       prev_valid = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic       prev_ferr  = 1'b0;
    exp_t       mon_e;

    always @(negedge clk) begin
        if (rst_n) begin
            if ((rbr_valid && (!prev_valid || data_out != prev_data)) ||
                (framing_err && !prev_ferr)) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected event: data=0x%0h valid=%0b ferr=%0b ovr=%0b, expected no event",
                             data_out, rbr_valid, framing_err, overrun);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("scoreboard {data,valid,ferr,ovr}",
                          32'({data_out, rbr_valid, framing_err, overrun}), 32'(mon_e));
                end
            end
        end
        prev_valid = rbr_valid;
        prev_data  = data_out;
        prev_ferr  = framing_err;
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("reset Data_out", 32'(data_out), 32'h00);
        check("reset RBR_Valid", 32'(rbr_valid), 32'd0);
        check("reset Framing_Err", 32'(framing_err), 32'd0);
        check("reset Overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        idle(5);

        // 1: single frame with exact latency, then acknowledge
        exp_q.push_back(mk(8'hA5, 1'b1, 1'b0, 1'b0));
        send_timed(8'hA5, "t1");
        check("t1 Framing_Err", 32'(framing_err), 32'd0);
        check("t1 Overrun", 32'(overrun), 32'd0);
        rbr_rd = 1'b1;
        @(negedge clk);
        rbr_rd = 1'b0;
        check("t1 valid after ack", 32'(rbr_valid), 32'd0);
        check("t1 data kept after ack", 32'(data_out), 32'hA5);

        // 2: start glitch of 4 clocks is rejected
        idle(4);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        idle(40);
        check("t2 RBR_Valid", 32'(rbr_valid), 32'd0);
        check("t2 Framing_Err", 32'(framing_err), 32'd0);
        check("t2 Overrun", 32'(overrun), 32'd0);

        // 3: stop bit low with line held low, then a good frame
        exp_q.push_back(mk(8'hA5, 1'b0, 1'b1, 1'b0));
        send_frame(8'h3C, 1'b0, 3 * C);
        check("t3 Framing_Err", 32'(framing_err), 32'd1);
        check("t3 RBR_Valid", 32'(rbr_valid), 32'd0);
        check("t3 Data_out unchanged", 32'(data_out), 32'hA5);
        idle(2 * C);
        exp_q.push_back(mk(8'h55, 1'b1, 1'b1, 1'b0));
        send_frame(8'h55, 1'b1, C);
        check("t3 follow-up data", 32'(data_out), 32'h55);
        ack();
        check("t3 Framing_Err after ack", 32'(framing_err), 32'd0);
        idle(C);

        // 4: back-to-back frames without acknowledge -> overrun
        exp_q.push_back(mk(8'h01, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(8'hFF, 1'b1, 1'b0, 1'b1));
        send_frame(8'h01, 1'b1, C);
        send_frame(8'hFF, 1'b1, C);
        idle(C);
        check("t4 Data_out", 32'(data_out), 32'hFF);
        check("t4 RBR_Valid", 32'(rbr_valid), 32'd1);
        check("t4 Overrun", 32'(overrun), 32'd1);
        ack();
        check("t4 RBR_Valid after ack", 32'(rbr_valid), 32'd0);
        check("t4 Overrun after ack", 32'(overrun), 32'd0);
        idle(2 * C);

        // 5: acknowledge in exactly the cycle the second byte loads
        exp_q.push_back(mk(8'h01, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(8'hFF, 1'b1, 1'b0, 1'b0));
        fork
            begin
                send_frame(8'h01, 1'b1, C);
                send_frame(8'hFF, 1'b1, C);
            end
            begin
                repeat (10 * C) @(negedge clk);
                repeat (154) @(posedge clk);
                @(negedge clk);
                rbr_rd = 1'b1;
                @(negedge clk);
                rbr_rd = 1'b0;
            end
        join
        check("t5 RBR_Valid", 32'(rbr_valid), 32'd1);
        check("t5 Data_out", 32'(data_out), 32'hFF);
        check("t5 Overrun", 32'(overrun), 32'd0);
        ack();
        idle(2 * C);

        // 6: reset mid bit 4 of 0x81 clears outputs at once
        fork
            send_frame(8'h81, 1'b1, C);
            begin
                repeat (C + 4 * C + C / 2) @(negedge clk);
                rst_n = 1'b0;
                #1;
                check("t6 reset Data_out", 32'(data_out), 32'h00);
                check("t6 reset RBR_Valid", 32'(rbr_valid), 32'd0);
                check("t6 reset Framing_Err", 32'(framing_err), 32'd0);
                check("t6 reset Overrun", 32'(overrun), 32'd0);
            end
        join
        idle(C);
        rst_n = 1'b1;
        idle(C);
        exp_q.push_back(mk(8'h7E, 1'b1, 1'b0, 1'b0));
        send_timed(8'h7E, "t6");
        ack();

        // Loopback sweep: every byte value from the bench transmitter
        for (int b = 0; b < 256; b++) begin
            exp_q.push_back(mk(8'(b), 1'b1, 1'b0, 1'b0));
            send_frame(8'(b), 1'b1, C);
            ack();
        end

        idle(2 * C);
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
